// File: rtl/stream_serializer_pkg.sv
// stream_serializer_pkg
//   Shared helpers for the width-reducing stream serializer.
//   idx_width(count) : width of the beat counter that walks the elements
//                      of one held word (at least 1 bit, even for count 1).
package stream_serializer_pkg;

  function automatic int idx_width(input int count);
    if (count > 1) begin
      return $clog2(count);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/stream_serializer_reg.sv
// stream_serializer_reg
//   Enabled state register with synchronous active-high reset.
//   Ports:
//     clk  : clock
//     rst  : synchronous reset, loads RESET_VAL
//     en   : load enable; q holds its value while low
//     d    : next value
//     q    : registered value
module stream_serializer_reg #(
  parameter int             W         = 1,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // State update: reset has priority, otherwise load on enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/stream_serializer.sv
// stream_serializer
//   Accepts one wide word of COUNT packed elements per input handshake and
//   emits the elements one per output beat, element 0 (LSB slice) first.
//   A single holding register plus a beat counter absorbs the rate mismatch;
//   the next word is taken on the same cycle as the last beat leaves, so a
//   saturated stream has no bubbles.
//   Ports:
//     clk, rst            : clock, synchronous active-high reset
//     stream_in_valid     : wide word offered
//     stream_in_ready     : word accepted this cycle when valid (combinational
//                           from stream_out_ready)
//     stream_in_payload   : COUNT elements, element k at [k*ELEM_W +: ELEM_W]
//     stream_out_valid    : element available
//     stream_out_ready    : downstream takes the element
//     stream_out_payload  : current element
module stream_serializer
  import stream_serializer_pkg::*;
#(
  parameter type T     = logic,
  parameter int  COUNT = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stream_in_valid,
  output logic                        stream_in_ready,
  input  logic [COUNT*$bits(T)-1:0]   stream_in_payload,
  output logic                        stream_out_valid,
  input  logic                        stream_out_ready,
  output logic [$bits(T)-1:0]         stream_out_payload
);

  localparam int ELEM_W = $bits(T);
  localparam int WORD_W = COUNT * ELEM_W;
  localparam int IDX_W  = idx_width(COUNT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COUNT - 1);

  if (COUNT < 1) begin : g_bad_count
    $error("stream_serializer: COUNT must be at least 1");
  end

  logic [WORD_W-1:0] held_r;
  logic              held_valid_r;
  logic [IDX_W-1:0]  index_r;

  logic [WORD_W-1:0] held_nxt_s;
  logic              held_valid_nxt_s;
  logic [IDX_W-1:0]  index_nxt_s;
  logic              held_en_s;
  logic              held_valid_en_s;
  logic              index_en_s;

  logic              last_s;
  logic              in_ready_s;
  logic              in_fire_s;
  logic              out_fire_s;

  // For COUNT == 1 index_r stays 0, so last_s is always 1 and the block
  // degenerates to a plain registered stage.
  assign last_s = (index_r == LAST_IDX);

  // Handshakes and next-state selection; input acceptance wins over beat
  // advance so a last-beat out_fire can coincide with loading the next word.
  always_comb begin
    in_ready_s       = (!held_valid_r) || (stream_out_ready && last_s);
    in_fire_s        = stream_in_valid && in_ready_s;
    out_fire_s       = held_valid_r && stream_out_ready;

    held_nxt_s       = held_r;
    held_valid_nxt_s = held_valid_r;
    index_nxt_s      = index_r;
    held_en_s        = 1'b0;
    held_valid_en_s  = 1'b0;
    index_en_s       = 1'b0;

    if (in_fire_s) begin
      held_en_s        = 1'b1;
      held_nxt_s       = stream_in_payload;
      held_valid_en_s  = 1'b1;
      held_valid_nxt_s = 1'b1;
      index_en_s       = 1'b1;
      index_nxt_s      = {IDX_W{1'b0}};
    end else if (out_fire_s && last_s) begin
      held_valid_en_s  = 1'b1;
      held_valid_nxt_s = 1'b0;
      index_en_s       = 1'b1;
      index_nxt_s      = {IDX_W{1'b0}};
    end else if (out_fire_s) begin
      // index never passes COUNT-1 here, so no wrap is required.
      index_en_s       = 1'b1;
      index_nxt_s      = index_r + IDX_W'(1);
    end else begin
      held_en_s        = 1'b0;
      held_valid_en_s  = 1'b0;
      index_en_s       = 1'b0;
    end
  end

  stream_serializer_reg #(.W(1), .RESET_VAL(1'b0)) u_held_valid (
    .clk (clk),
    .rst (rst),
    .en  (held_valid_en_s),
    .d   (held_valid_nxt_s),
    .q   (held_valid_r)
  );

  stream_serializer_reg #(.W(IDX_W), .RESET_VAL({IDX_W{1'b0}})) u_index (
    .clk (clk),
    .rst (rst),
    .en  (index_en_s),
    .d   (index_nxt_s),
    .q   (index_r)
  );

  stream_serializer_reg #(.W(WORD_W), .RESET_VAL({WORD_W{1'b0}})) u_held (
    .clk (clk),
    .rst (rst),
    .en  (held_en_s),
    .d   (held_nxt_s),
    .q   (held_r)
  );

  assign stream_in_ready    = in_ready_s;
  assign stream_out_valid   = held_valid_r;
  assign stream_out_payload = held_r[index_r*ELEM_W +: ELEM_W];

endmodule

// File: tb/tb_stream_serializer.sv
// tb_stream_serializer
//   Drives a COUNT=4 byte serializer through directed scenarios and both it
//   and a COUNT=1 instance through a randomized phase. Expected outputs come
//   from a queue model: an accepted word pushes its bytes, each output beat
//   pops one, and the input is ready when the queue is empty or about to
//   lose its final byte.
module tb_stream_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [31:0] in_payload4;
  logic [7:0]  out_payload4;
  logic        in_valid1, in_ready1, out_valid1, out_ready1;
  logic [7:0]  in_payload1, out_payload1;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] q4[$];
  logic [7:0] q1[$];
  logic [7:0] idle4 = 8'h00;
  logic [7:0] idle1 = 8'h00;
  bit         acc4;

  stream_serializer #(.T(logic [7:0]), .COUNT(4)) dut4 (
    .clk                (clk),
    .rst                (rst),
    .stream_in_valid    (in_valid4),
    .stream_in_ready    (in_ready4),
    .stream_in_payload  (in_payload4),
    .stream_out_valid   (out_valid4),
    .stream_out_ready   (out_ready4),
    .stream_out_payload (out_payload4)
  );

  stream_serializer #(.T(logic [7:0]), .COUNT(1)) dut1 (
    .clk                (clk),
    .rst                (rst),
    .stream_in_valid    (in_valid1),
    .stream_in_ready    (in_ready1),
    .stream_in_payload  (in_payload1),
    .stream_out_valid   (out_valid1),
    .stream_out_ready   (out_ready1),
    .stream_out_payload (out_payload1)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check against the model, advance the model.
  task automatic cycle(input logic r,
                       input logic iv4, input logic [31:0] ip4, input logic or4,
                       input logic iv1, input logic [7:0] ip1, input logic or1);
    logic rdy4, rdy1;
    logic [7:0] exp_p4, exp_p1;
    rst         = r;
    in_valid4   = iv4;
    in_payload4 = ip4;
    out_ready4  = or4;
    in_valid1   = iv1;
    in_payload1 = ip1;
    out_ready1  = or1;
    #1;
    rdy4   = (q4.size() == 0) || (or4 && q4.size() == 1);
    rdy1   = (q1.size() == 0) || (or1 && q1.size() == 1);
    exp_p4 = (q4.size() != 0) ? q4[0] : idle4;
    exp_p1 = (q1.size() != 0) ? q1[0] : idle1;
    check_value("valid4",   32'(out_valid4),   32'(q4.size() != 0));
    check_value("ready4",   32'(in_ready4),    32'(rdy4));
    check_value("payload4", 32'(out_payload4), 32'(exp_p4));
    check_value("valid1",   32'(out_valid1),   32'(q1.size() != 0));
    check_value("ready1",   32'(in_ready1),    32'(rdy1));
    check_value("payload1", 32'(out_payload1), 32'(exp_p1));
    @(posedge clk);
    acc4 = 1'b0;
    if (r) begin
      q4.delete();
      q1.delete();
      idle4 = 8'h00;
      idle1 = 8'h00;
    end else begin
      if (q4.size() != 0 && or4) void'(q4.pop_front());
      if (iv4 && rdy4) begin
        for (int k = 0; k < 4; k++) q4.push_back(ip4[k*8 +: 8]);
        idle4 = ip4[7:0];
        acc4  = 1'b1;
      end
      if (q1.size() != 0 && or1) void'(q1.pop_front());
      if (iv1 && rdy1) begin
        q1.push_back(ip1);
        idle1 = ip1;
      end
    end
    @(negedge clk);
  endtask

  // Offer a word to the COUNT=4 instance until the model says it was taken.
  task automatic send4(input logic [31:0] w);
    int n = 0;
    acc4 = 1'b0;
    while (!acc4 && n < 8) begin
      cycle(1'b0, 1'b1, w, 1'b1, 1'b0, 8'h00, 1'b1);
      n++;
    end
    check_value("accept4", 32'(acc4), 32'd1);
  endtask

  task automatic idle(input int n, input logic or4);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, or4, 1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid4 = 1'b0; in_payload4 = 32'h0; out_ready4 = 1'b1;
    in_valid1 = 1'b0; in_payload1 = 8'h00; out_ready1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset held with valid input: nothing may be captured.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 32'h44332211, 1'b1, 1'b1, 8'h5A, 1'b1);
    idle(1, 1'b1);

    // Single word, continuous ready.
    send4(32'h44332211);
    idle(5, 1'b1);

    // Back-to-back words; second is taken on the 0x44 beat.
    send4(32'h44332211);
    send4(32'h88776655);
    idle(5, 1'b1);

    // Backpressure on the 0x22 beat.
    send4(32'h44332211);
    idle(1, 1'b1);
    idle(3, 1'b0);
    idle(4, 1'b1);

    // Reset after 0x22 leaves, then a fresh word.
    send4(32'h44332211);
    idle(2, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 8'h00, 1'b1);
    send4(32'hDDCCBBAA);
    idle(5, 1'b1);

    // Randomized traffic on both instances with rare resets.
    for (int i = 0; i < 1000; i++) begin
      logic r, iv4, or4, iv1, or1;
      r   = ($urandom_range(0, 199) == 0);
      iv4 = 1'($urandom_range(0, 1));
      or4 = ($urandom_range(0, 3) != 0);
      iv1 = 1'($urandom_range(0, 1));
      or1 = 1'($urandom_range(0, 1));
      cycle(r, iv4, $urandom, or4, iv1, 8'($urandom), or1);
    end
    idle(6, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
